// File: rtl/mem_arb_pkg.sv
// mem_arb_pkg: shared definitions for the external SRAM arbiter.
//   - state_t    : four-phase SRAM access sequence (IDLE, SETUP, STROBE, HOLD)
//   - ADR_W_DEF / DAT_W_DEF : default SRAM address and data widths
//   - PORT0 / PORT1 / N_PORTS : requester indices
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    STROBE = 2'd2,
    HOLD   = 2'd3
  } state_t;

  localparam int ADR_W_DEF = 21;
  localparam int DAT_W_DEF = 8;

  localparam int   N_PORTS = 2;
  localparam logic PORT0   = 1'b0;  // program loader
  localparam logic PORT1   = 1'b1;  // CPU / DMA bus

endpackage

// File: rtl/mem_arb_pick.sv
// mem_arb_pick: combinational winner selection for the SRAM arbiter.
// Ports:
//   last_grant  in   port granted most recently (round-robin build only)
//   req         in   request vector, bit i = port i
//   any_req     out  at least one port is requesting
//   winner      out  index of the port that gets the next access
// Build option MEM_ARB_ROUND_ROBIN_EN:
//   defined   - on a tie the port not granted last wins
//   undefined - port 0 always wins a tie
// With a single requester both builds pick that requester.
module mem_arb_pick
  import mem_arb_pkg::*;
(
`ifdef MEM_ARB_ROUND_ROBIN_EN
  input  logic               last_grant,
`endif
  input  logic [N_PORTS-1:0] req,
  output logic               any_req,
  output logic               winner
);

  assign any_req = |req;

  always_comb begin
    winner = PORT0;
    if (req[PORT0] && req[PORT1]) begin
`ifdef MEM_ARB_ROUND_ROBIN_EN
      winner = ~last_grant;
`else
      winner = PORT0;
`endif
    end else if (req[PORT1]) begin
      winner = PORT1;
    end
  end

endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: two-port arbiter and sequencer for a shared external SRAM.
// Every access runs IDLE -> SETUP -> STROBE -> HOLD; the winning port's
// request is latched in IDLE so later changes on its inputs do not disturb
// the access in flight.
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   pN_req/adr/write/wdata      requester N access (req held until ack)
//   pN_ack                      one-cycle completion pulse (in HOLD)
//   pN_rdata                    read data, updated only on port N read ack
//   sram_adr/dout/drive         SRAM address, write data, data-pin enable
//   sram_we/sram_oe             active-high write/read strobes
//   sram_din                    data from SRAM
// Build option MEM_ARB_ROUND_ROBIN_EN selects round-robin tie breaking
// (last-grant register present); otherwise port 0 has fixed priority.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADR_W = ADR_W_DEF,
  parameter int DAT_W = DAT_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             p0_req,
  input  logic [ADR_W-1:0] p0_adr,
  input  logic             p0_write,
  input  logic [DAT_W-1:0] p0_wdata,
  output logic             p0_ack,
  output logic [DAT_W-1:0] p0_rdata,
  input  logic             p1_req,
  input  logic [ADR_W-1:0] p1_adr,
  input  logic             p1_write,
  input  logic [DAT_W-1:0] p1_wdata,
  output logic             p1_ack,
  output logic [DAT_W-1:0] p1_rdata,
  output logic [ADR_W-1:0] sram_adr,
  output logic [DAT_W-1:0] sram_dout,
  output logic             sram_drive,
  output logic             sram_we,
  output logic             sram_oe,
  input  logic [DAT_W-1:0] sram_din
);

  state_t           state_reg, state_next;
  logic             grant_reg, grant_next;
  logic             write_reg, write_next;
  logic [ADR_W-1:0] adr_reg, adr_next;
  logic [DAT_W-1:0] dout_reg, dout_next;
  logic             we_reg, we_next;
  logic             oe_reg, oe_next;
  logic             drive_reg, drive_next;

  logic [N_PORTS-1:0] req_vec;
  logic [N_PORTS-1:0] write_vec;
  logic [N_PORTS-1:0] ack_vec;
  logic [ADR_W-1:0]   adr_vec   [N_PORTS];
  logic [DAT_W-1:0]   wdata_vec [N_PORTS];
  logic [DAT_W-1:0]   rdata_vec [N_PORTS];

  logic any_req;
  logic winner;

  assign req_vec   = {p1_req, p0_req};
  assign write_vec = {p1_write, p0_write};
  assign adr_vec[PORT0]   = p0_adr;
  assign adr_vec[PORT1]   = p1_adr;
  assign wdata_vec[PORT0] = p0_wdata;
  assign wdata_vec[PORT1] = p1_wdata;

`ifdef MEM_ARB_ROUND_ROBIN_EN
  logic last_grant_reg;

  // Resets to port 1 so that port 0 wins the very first tie.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      last_grant_reg <= PORT1;
    end else if (state_reg == IDLE && any_req) begin
      last_grant_reg <= winner;
    end
  end
`endif

  mem_arb_pick u_pick (
`ifdef MEM_ARB_ROUND_ROBIN_EN
    .last_grant (last_grant_reg),
`endif
    .req        (req_vec),
    .any_req    (any_req),
    .winner     (winner)
  );

  // State and SRAM-side registers. Async reset drops strobes and drive at
  // once, abandoning any access in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg <= IDLE;
      grant_reg <= PORT0;
      write_reg <= 1'b0;
      adr_reg   <= '0;
      dout_reg  <= '0;
      we_reg    <= 1'b0;
      oe_reg    <= 1'b0;
      drive_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      grant_reg <= grant_next;
      write_reg <= write_next;
      adr_reg   <= adr_next;
      dout_reg  <= dout_next;
      we_reg    <= we_next;
      oe_reg    <= oe_next;
      drive_reg <= drive_next;
    end
  end

  // Next-state and next-output logic. Outputs are registered, so each
  // value computed here appears during the following state.
  always_comb begin
    state_next = state_reg;
    grant_next = grant_reg;
    write_next = write_reg;
    adr_next   = adr_reg;
    dout_next  = dout_reg;
    we_next    = 1'b0;
    oe_next    = 1'b0;
    drive_next = drive_reg;
    unique case (state_reg)
      IDLE: begin
        drive_next = 1'b0;
        if (any_req) begin
          state_next = SETUP;
          grant_next = winner;
          write_next = write_vec[winner];
          adr_next   = adr_vec[winner];
          dout_next  = wdata_vec[winner];
          drive_next = write_vec[winner];
        end
      end
      SETUP: begin
        state_next = STROBE;
        we_next    = write_reg;
        oe_next    = ~write_reg;
      end
      STROBE: begin
        state_next = HOLD;
      end
      HOLD: begin
        state_next = IDLE;
        drive_next = 1'b0;
      end
      default: begin
        state_next = IDLE;
        drive_next = 1'b0;
      end
    endcase
  end

  // Per-port ack and read-data registers. The ack is raised on the edge
  // that ends STROBE, the same edge on which read data is sampled.
  for (genvar gi = 0; gi < N_PORTS; gi++) begin : g_port
    logic             ack_reg;
    logic             ack_next;
    logic [DAT_W-1:0] rdata_reg;

    assign ack_next = (state_reg == STROBE) && (grant_reg == 1'(gi));

    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        ack_reg   <= 1'b0;
        rdata_reg <= '0;
      end else begin
        ack_reg <= ack_next;
        if (ack_next && !write_reg) begin
          rdata_reg <= sram_din;
        end
      end
    end

    assign ack_vec[gi]   = ack_reg;
    assign rdata_vec[gi] = rdata_reg;
  end

  assign p0_ack     = ack_vec[PORT0];
  assign p1_ack     = ack_vec[PORT1];
  assign p0_rdata   = rdata_vec[PORT0];
  assign p1_rdata   = rdata_vec[PORT1];
  assign sram_adr   = adr_reg;
  assign sram_dout  = dout_reg;
  assign sram_drive = drive_reg;
  assign sram_we    = we_reg;
  assign sram_oe    = oe_reg;

endmodule
